// File: rtl/fetch_unit.sv
// Instruction fetch stage: drives the PC to a combinational instruction memory and
// registers the returned word toward decode under a valid/ready handshake.
module fetch_unit #(
   parameter int ADDR_W  = 5,
   parameter int INSTR_W = 16
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic               start,
   input  logic               stall,
   input  logic               branch_taken,
   input  logic [ADDR_W-1:0]  branch_target,
   output logic [ADDR_W-1:0]  instr_address,
   input  logic [INSTR_W-1:0] instr_in,
   output logic [INSTR_W-1:0] if_instr,
   output logic [ADDR_W-1:0]  if_pc,
   output logic               if_valid,
   input  logic               if_ready,
   output logic               halted,
   output logic [7:0]         fetch_count
);

   typedef enum logic [1:0] {S_IDLE, S_FETCH, S_HALT} state_t;

   state_t               state_q, state_d;
   logic [ADDR_W-1:0]    pc_q, pc_d;
   logic [INSTR_W-1:0]   instr_q, instr_d;
   logic [ADDR_W-1:0]    ifpc_q, ifpc_d;
   logic                 valid_q, valid_d;
   logic [7:0]           cnt_q, cnt_d;
   logic                 is_halt;
   logic                 load;

   assign is_halt = (instr_in[INSTR_W-1 -: 3] == 3'b111);
   // A slot is free when nothing is held or decode takes the held word this cycle.
   assign load    = (state_q == S_FETCH) && !stall && !branch_taken && (!valid_q || if_ready);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= S_IDLE;
         pc_q    <= '0;
         instr_q <= '0;
         ifpc_q  <= '0;
         valid_q <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         instr_q <= instr_d;
         ifpc_q  <= ifpc_d;
         valid_q <= valid_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (start) state_d = S_FETCH;
         S_FETCH: if (load && is_halt) state_d = S_HALT;
         S_HALT:  if (branch_taken || start) state_d = S_FETCH;
         default: state_d = S_IDLE;
      endcase
   end

   // Branch outranks every other event in FETCH and HALT; IDLE ignores it.
   always_comb begin
      pc_d    = pc_q;
      instr_d = instr_q;
      ifpc_d  = ifpc_q;
      valid_d = valid_q;
      cnt_d   = cnt_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               pc_d    = '0;
               cnt_d   = '0;
               valid_d = 1'b0;
            end
         end
         S_FETCH: begin
            if (branch_taken) begin
               pc_d    = branch_target;
               valid_d = 1'b0;
            end else if (load) begin
               if (is_halt) begin
                  valid_d = 1'b0;
               end else begin
                  instr_d = instr_in;
                  ifpc_d  = pc_q;
                  valid_d = 1'b1;
                  pc_d    = pc_q + 1'b1;
                  if (cnt_q != 8'hFF) cnt_d = cnt_q + 8'd1;
               end
            end else if (valid_q && if_ready) begin
               valid_d = 1'b0;
            end
         end
         S_HALT: begin
            if (branch_taken) begin
               pc_d    = branch_target;
               valid_d = 1'b0;
            end else if (start) begin
               pc_d    = '0;
               cnt_d   = '0;
               valid_d = 1'b0;
            end
         end
         default: valid_d = 1'b0;
      endcase
   end

   always_comb begin
      instr_address = pc_q;
      if_instr      = instr_q;
      if_pc         = ifpc_q;
      if_valid      = valid_q;
      halted        = (state_q == S_HALT);
      fetch_count   = cnt_q;
   end

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: a reference model predicts each post-edge
// output snapshot, a monitor pops and compares it one time unit after the edge.
module tb_fetch_unit;

   localparam int ADDR_W  = 5;
   localparam int INSTR_W = 16;
   localparam int DEPTH   = 1 << ADDR_W;

   logic               clk = 1'b0;
   logic               reset_n;
   logic               start, stall, br, rdy;
   logic [ADDR_W-1:0]  tgt;
   logic [ADDR_W-1:0]  instr_address;
   logic [INSTR_W-1:0] instr_in;
   logic [INSTR_W-1:0] if_instr;
   logic [ADDR_W-1:0]  if_pc;
   logic               if_valid;
   logic               halted;
   logic [7:0]         fetch_count;

   logic [INSTR_W-1:0] mem [DEPTH];

   int n_total = 0;
   int n_pass  = 0;

   typedef struct {
      logic        v;
      int          addr;
      logic [15:0] ins;
      int          ipc;
      logic        h;
      int          cnt;
   } snap_t;
   snap_t sbq[$];

   always #5 clk = ~clk;

   assign instr_in = mem[instr_address];

   fetch_unit #(.ADDR_W(ADDR_W), .INSTR_W(INSTR_W)) dut (
      .clk(clk), .reset_n(reset_n), .start(start), .stall(stall),
      .branch_taken(br), .branch_target(tgt), .instr_address(instr_address),
      .instr_in(instr_in), .if_instr(if_instr), .if_pc(if_pc), .if_valid(if_valid),
      .if_ready(rdy), .halted(halted), .fetch_count(fetch_count)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
   endtask

   function automatic logic [15:0] rand_word(input int halt_pct);
      logic [15:0] w;
      w = 16'($urandom);
      if (int'($urandom_range(0, 99)) < halt_pct) w[15:13] = 3'b111;
      else if (w[15:13] == 3'b111) w[13] = 1'b0;
      return w;
   endfunction

   // Reference model: mode 0=idle, 1=fetching, 2=halted.
   initial begin
      int    m_mode, m_pc, m_ipc, m_cnt;
      logic  m_v;
      logic [15:0] m_ins, w;
      snap_t s;
      m_mode = 0; m_pc = 0; m_ipc = 0; m_cnt = 0; m_v = 0; m_ins = '0;
      forever begin
         @(posedge clk);
         if (!reset_n) begin
            m_mode = 0; m_pc = 0; m_ipc = 0; m_cnt = 0; m_v = 0; m_ins = '0;
         end else if (m_mode == 0) begin
            if (start) begin m_mode = 1; m_pc = 0; m_cnt = 0; m_v = 0; end
         end else if (br) begin
            m_mode = 1; m_pc = int'(tgt); m_v = 0;
         end else if (m_mode == 2) begin
            if (start) begin m_mode = 1; m_pc = 0; m_cnt = 0; m_v = 0; end
         end else if (!stall && (!m_v || rdy)) begin
            w = mem[m_pc];
            if (w[15:13] == 3'b111) begin
               m_v = 0; m_mode = 2;
            end else begin
               m_ins = w; m_ipc = m_pc; m_v = 1;
               m_pc = (m_pc + 1) % DEPTH;
               if (m_cnt < 255) m_cnt = m_cnt + 1;
            end
         end else if (m_v && rdy) begin
            m_v = 0;
         end
         s.v = m_v; s.addr = m_pc; s.ins = m_ins; s.ipc = m_ipc;
         s.h = (m_mode == 2); s.cnt = m_cnt;
         sbq.push_back(s);
      end
   end

   initial begin
      snap_t e;
      forever begin
         @(posedge clk);
         #1;
         if (sbq.size() == 0) begin
            check("sb_underflow", 32'd0, 32'd1);
         end else begin
            e = sbq.pop_front();
            check("if_valid",      32'(if_valid),      32'(e.v));
            check("instr_address", 32'(instr_address), 32'(e.addr));
            check("halted",        32'(halted),        32'(e.h));
            check("fetch_count",   32'(fetch_count),   32'(e.cnt));
            check("if_pc",         32'(if_pc),         32'(e.ipc));
            check("if_instr",      32'(if_instr),      32'(e.ins));
         end
      end
   end

   task automatic wait_halt(input string name);
      int k;
      k = 0;
      while (!halted && k < 60) begin @(negedge clk); k++; end
      check(name, 32'(halted), 32'd1);
   endtask

   task automatic pulse_start();
      start = 1'b1; @(negedge clk); start = 1'b0;
   endtask

   initial begin
      reset_n = 1'b0; start = 0; stall = 0; br = 0; rdy = 0; tgt = '0;
      for (int i = 0; i < DEPTH; i++) mem[i] = rand_word(0);
      #3;
      check("rst_valid", 32'(if_valid), 32'd0);
      check("rst_addr",  32'(instr_address), 32'd0);
      check("rst_instr", 32'(if_instr), 32'd0);
      check("rst_ifpc",  32'(if_pc), 32'd0);
      check("rst_halt",  32'(halted), 32'd0);
      check("rst_count", 32'(fetch_count), 32'd0);
      repeat (3) @(negedge clk);
      reset_n = 1'b1;
      repeat (2) @(negedge clk);

      // Straight-line fetch, then decode back-pressure while if_pc=2 is held.
      rdy = 1'b1;
      pulse_start();
      repeat (3) @(negedge clk);
      rdy = 1'b0;
      repeat (3) @(negedge clk);
      rdy = 1'b1;
      repeat (5) @(negedge clk);

      // Flush and redirect to 5, then run into a halt word at 9.
      mem[9] = 16'b111_0_0000_0000_0000;
      br = 1'b1; tgt = 5'd5;
      @(negedge clk);
      br = 1'b0;
      wait_halt("halt_at_9");
      stall = 1'b1;
      repeat (2) @(negedge clk);
      stall = 1'b0;
      // start with branch in HALT: branch wins.
      start = 1'b1; br = 1'b1; tgt = 5'd12;
      @(negedge clk);
      start = 1'b0; br = 1'b0;
      repeat (3) @(negedge clk);
      br = 1'b1; tgt = 5'd7;
      @(negedge clk);
      br = 1'b0;
      wait_halt("halt_again");
      repeat (2) @(negedge clk);
      pulse_start();
      mem[9] = rand_word(0);

      // Long clean run: PC wraps at 31 and fetch_count saturates at 255.
      repeat (300) @(negedge clk);

      // Randomized traffic with occasional halt words.
      for (int i = 0; i < DEPTH; i++) mem[i] = rand_word(12);
      for (int c = 0; c < 600; c++) begin
         stall = ($urandom_range(0, 3) == 0);
         rdy   = ($urandom_range(0, 9) < 7);
         br    = ($urandom_range(0, 9) == 0);
         tgt   = ADDR_W'($urandom);
         start = ($urandom_range(0, 19) == 0);
         @(negedge clk);
      end
      stall = 0; br = 0; start = 0;

      // Asynchronous reset between edges while an instruction is held.
      for (int i = 0; i < DEPTH; i++) mem[i] = rand_word(0);
      pulse_start();
      rdy = 1'b0;
      repeat (4) @(negedge clk);
      check("pre_rst_valid", 32'(if_valid), 32'd1);
      #2 reset_n = 1'b0;
      #1;
      check("async_valid", 32'(if_valid), 32'd0);
      check("async_addr",  32'(instr_address), 32'd0);
      check("async_count", 32'(fetch_count), 32'd0);
      @(negedge clk);
      @(negedge clk);
      reset_n = 1'b1;
      rdy = 1'b1;
      repeat (4) @(negedge clk);
      pulse_start();
      repeat (6) @(negedge clk);

      repeat (2) @(negedge clk);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
